// File: rtl/sudoku_pkg.sv
// Shared constants, row-word field offsets, box indexing and FSM state type
// for the Sudoku board checker.
package sudoku_pkg;

  localparam int N_DEF   = 4;
  localparam int BOX_DEF = 2;
  localparam int DW_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    EVAL  = 2'd3
  } state_t;

  function automatic int digit_lsb(input int dw, input int c);
    return c * dw;
  endfunction

  function automatic int blank_bit(input int n, input int dw, input int c);
    return n * dw + c;
  endfunction

  function automatic int wp_bit(input int n, input int dw, input int c);
    return n * (dw + 1) + c;
  endfunction

  function automatic int box_index(input int r, input int c, input int box);
    return (r / box) * box + c / box;
  endfunction

endpackage

// File: rtl/digit_onehot.sv
// Decodes one stored cell (digit + blank flag) into a one-hot digit and
// valid/invalid classification; blank cells are neither valid nor invalid.
module digit_onehot #(
  parameter int N  = 4,
  parameter int DW = 4
) (
  input  logic [DW-1:0] digit,
  input  logic          blank,
  output logic [N-1:0]  onehot,
  output logic          valid,
  output logic          invalid
);

  always_comb begin
    valid   = 1'b0;
    invalid = 1'b0;
    onehot  = '0;
    if (!blank) begin
      if (digit == '0 || int'(digit) > N) invalid = 1'b1;
      else                                valid   = 1'b1;
    end
    for (int i = 0; i < N; i++) onehot[i] = valid && (int'(digit) == i + 1);
  end

endmodule

// File: rtl/sudoku_grid_checker.sv
// Scans an N x N board from game RAM one row per cycle and reports completion,
// conflicts and per-row/column/box bad masks with a one-cycle done pulse.
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int BOX = BOX_DEF,
  parameter int DW  = DW_DEF,
  parameter int AW  = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [AW-1:0]     RamAddr,
  output logic              RamRe,
  input  logic [N*(DW+2)-1:0] RamDat,
  output logic              busy,
  output logic              done,
  output logic              gameComplete,
  output logic              conflict,
  output logic [N-1:0]      rowBad,
  output logic [N-1:0]      colBad,
  output logic [N-1:0]      boxBad,
  output logic [1:0]        dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE; the RAM
  // word for the address issued with RamRe=1 is sampled at the following edge.
  state_t state_q, state_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic ram_re_q, ram_re_d, busy_q, busy_d, done_q, done_d;

  logic [N-1:0][N-1:0] col_seen_q, col_seen_d, box_seen_q, box_seen_d;
  logic [N-1:0] row_bad_acc_q, row_bad_acc_d;
  logic [N-1:0] col_bad_acc_q, col_bad_acc_d, box_bad_acc_q, box_bad_acc_d;
  logic any_blank_q, any_blank_d, any_invalid_q, any_invalid_d;
  logic conflict_acc_q, conflict_acc_d;

  logic [N-1:0] row_bad_q, row_bad_d, col_bad_q, col_bad_d, box_bad_q, box_bad_d;
  logic game_complete_q, game_complete_d, conflict_q, conflict_d;

  logic [N-1:0][N-1:0] cell_oh;
  logic [N-1:0] cell_valid, cell_invalid, cell_blank;

  logic unused_wp;
  assign unused_wp = ^RamDat[wp_bit(N, DW, 0) +: N];

  for (genvar c = 0; c < N; c++) begin : g_cell
    assign cell_blank[c] = RamDat[blank_bit(N, DW, c)];
    digit_onehot #(.N(N), .DW(DW)) u_dec (
      .digit   (RamDat[digit_lsb(DW, c) +: DW]),
      .blank   (cell_blank[c]),
      .onehot  (cell_oh[c]),
      .valid   (cell_valid[c]),
      .invalid (cell_invalid[c])
    );
  end

  // Walk the row word left to right so duplicates inside one word are caught
  // against the masks already extended by earlier cells of the same word.
  logic [N-1:0] row_run;
  logic row_hit, row_inv, dup_any;
  logic [N-1:0][N-1:0] col_seen_nx, box_seen_nx;
  logic [N-1:0] col_bad_nx, box_bad_nx;

  always_comb begin
    row_run     = '0;
    row_hit     = 1'b0;
    row_inv     = 1'b0;
    dup_any     = 1'b0;
    col_seen_nx = col_seen_q;
    box_seen_nx = box_seen_q;
    col_bad_nx  = col_bad_acc_q;
    box_bad_nx  = box_bad_acc_q;
    for (int c = 0; c < N; c++) begin
      if (cell_invalid[c]) begin
        row_inv = 1'b1;
        col_bad_nx[c] = 1'b1;
        box_bad_nx[box_index(int'(ram_addr_q), c, BOX)] = 1'b1;
      end
      if (cell_valid[c]) begin
        if ((row_run & cell_oh[c]) != '0) begin
          row_hit = 1'b1;
          dup_any = 1'b1;
        end
        if ((col_seen_nx[c] & cell_oh[c]) != '0) begin
          col_bad_nx[c] = 1'b1;
          dup_any = 1'b1;
        end
        if ((box_seen_nx[box_index(int'(ram_addr_q), c, BOX)] & cell_oh[c]) != '0) begin
          box_bad_nx[box_index(int'(ram_addr_q), c, BOX)] = 1'b1;
          dup_any = 1'b1;
        end
        row_run = row_run | cell_oh[c];
        col_seen_nx[c] = col_seen_nx[c] | cell_oh[c];
        box_seen_nx[box_index(int'(ram_addr_q), c, BOX)] =
          box_seen_nx[box_index(int'(ram_addr_q), c, BOX)] | cell_oh[c];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ram_addr_d      = ram_addr_q;
    ram_re_d        = ram_re_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    col_seen_d      = col_seen_q;
    box_seen_d      = box_seen_q;
    row_bad_acc_d   = row_bad_acc_q;
    col_bad_acc_d   = col_bad_acc_q;
    box_bad_acc_d   = box_bad_acc_q;
    any_blank_d     = any_blank_q;
    any_invalid_d   = any_invalid_q;
    conflict_acc_d  = conflict_acc_q;
    row_bad_d       = row_bad_q;
    col_bad_d       = col_bad_q;
    box_bad_d       = box_bad_q;
    game_complete_d = game_complete_q;
    conflict_d      = conflict_q;

    if (ram_re_q) begin
      col_seen_d     = col_seen_nx;
      box_seen_d     = box_seen_nx;
      col_bad_acc_d  = col_bad_nx;
      box_bad_acc_d  = box_bad_nx;
      row_bad_acc_d[ram_addr_q] = row_bad_acc_q[ram_addr_q] | row_hit | row_inv;
      any_blank_d    = any_blank_q | (|cell_blank);
      any_invalid_d  = any_invalid_q | row_inv;
      conflict_acc_d = conflict_acc_q | dup_any;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          col_seen_d      = '0;
          box_seen_d      = '0;
          row_bad_acc_d   = '0;
          col_bad_acc_d   = '0;
          box_bad_acc_d   = '0;
          any_blank_d     = 1'b0;
          any_invalid_d   = 1'b0;
          conflict_acc_d  = 1'b0;
          row_bad_d       = '0;
          col_bad_d       = '0;
          box_bad_d       = '0;
          game_complete_d = 1'b0;
          conflict_d      = 1'b0;
          ram_addr_d      = '0;
          ram_re_d        = 1'b1;
          busy_d          = 1'b1;
          state_d         = SCAN;
        end
      end
      SCAN: begin
        if (ram_addr_q == AW'(N - 1)) begin
          ram_re_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          ram_addr_d = ram_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        row_bad_d       = row_bad_acc_q;
        col_bad_d       = col_bad_acc_q;
        box_bad_d       = box_bad_acc_q;
        conflict_d      = conflict_acc_q;
        game_complete_d = !any_blank_q && !any_invalid_q && (row_bad_acc_q == '0) &&
                          (col_bad_acc_q == '0) && (box_bad_acc_q == '0);
        done_d          = 1'b1;
        busy_d          = 1'b0;
        state_d         = EVAL;
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      ram_addr_q      <= '0;
      ram_re_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      col_seen_q      <= '0;
      box_seen_q      <= '0;
      row_bad_acc_q   <= '0;
      col_bad_acc_q   <= '0;
      box_bad_acc_q   <= '0;
      any_blank_q     <= 1'b0;
      any_invalid_q   <= 1'b0;
      conflict_acc_q  <= 1'b0;
      row_bad_q       <= '0;
      col_bad_q       <= '0;
      box_bad_q       <= '0;
      game_complete_q <= 1'b0;
      conflict_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ram_addr_q      <= ram_addr_d;
      ram_re_q        <= ram_re_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      col_seen_q      <= col_seen_d;
      box_seen_q      <= box_seen_d;
      row_bad_acc_q   <= row_bad_acc_d;
      col_bad_acc_q   <= col_bad_acc_d;
      box_bad_acc_q   <= box_bad_acc_d;
      any_blank_q     <= any_blank_d;
      any_invalid_q   <= any_invalid_d;
      conflict_acc_q  <= conflict_acc_d;
      row_bad_q       <= row_bad_d;
      col_bad_q       <= col_bad_d;
      box_bad_q       <= box_bad_d;
      game_complete_q <= game_complete_d;
      conflict_q      <= conflict_d;
    end
  end

  assign RamAddr      = ram_addr_q;
  assign RamRe        = ram_re_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign gameComplete = game_complete_q;
  assign conflict     = conflict_q;
  assign rowBad       = row_bad_q;
  assign colBad       = col_bad_q;
  assign boxBad       = box_bad_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed bench for the 4x4 board checker: combinational RAM model driven by
// RamAddr, hand-computed expected results checked with immediate assertions.
module tb_sudoku_grid_checker;
  import sudoku_pkg::*;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int W  = N * (DW + 2);

  logic CLK, RST, start;
  logic [1:0] RamAddr;
  logic RamRe, busy, done, gameComplete, conflict;
  logic [W-1:0] RamDat;
  logic [N-1:0] rowBad, colBad, boxBad;
  logic [1:0] dbg_state;

  logic [W-1:0] mem [N];
  int total = 0;
  int bad   = 0;
  int lat, n_done, done_at;

  assign RamDat = mem[RamAddr];

  sudoku_grid_checker #(.N(4), .BOX(2), .DW(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .RamAddr(RamAddr), .RamRe(RamRe),
    .RamDat(RamDat), .busy(busy), .done(done), .gameComplete(gameComplete),
    .conflict(conflict), .rowBad(rowBad), .colBad(colBad), .boxBad(boxBad),
    .dbg_state(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int d0, input int d1, input int d2,
                                      input int d3, input logic [3:0] blk);
    logic [W-1:0] w;
    w = '0;
    w[3:0]   = 4'(d0);
    w[7:4]   = 4'(d1);
    w[11:8]  = 4'(d2);
    w[15:12] = 4'(d3);
    w[19:16] = blk;
    w[23:20] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic load_solved();
    mem[0] = mk(1, 2, 3, 4, 4'b0000);
    mem[1] = mk(3, 4, 1, 2, 4'b0000);
    mem[2] = mk(2, 1, 4, 3, 4'b0000);
    mem[3] = mk(4, 3, 2, 1, 4'b0000);
  endtask

  // Pulses start, checks the address sequence and cleared outputs, waits
  // (bounded) for done and confirms it is a single-cycle pulse at E0+5.
  task automatic scan(input string tag);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      if (lat < 4) begin
        chk({tag, "_addr"}, 32'(RamAddr), lat);
        chk({tag, "_re"}, 32'(RamRe), 1);
      end
      if (lat == 1) chk({tag, "_cleared"}, {gameComplete, conflict, rowBad, colBad, boxBad}, 0);
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    load_solved();
    #12;
    chk("rst_addr", 32'(RamAddr), 0);
    chk("rst_re_busy_done", {RamRe, busy, done}, 0);
    chk("rst_results", {gameComplete, conflict, rowBad, colBad, boxBad}, 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK); RST = 1'b0;

    // solved board
    scan("solved");
    chk("solved_gc", 32'(gameComplete), 1);
    chk("solved_conf", 32'(conflict), 0);
    chk("solved_masks", {rowBad, colBad, boxBad}, 0);
    repeat (3) @(negedge CLK);
    chk("solved_hold", 32'(gameComplete), 1);

    // row 1 = 3 4 1 1: dup in row1, column3, box1
    mem[1] = mk(3, 4, 1, 1, 4'b0000);
    scan("dup");
    chk("dup_gc", 32'(gameComplete), 0);
    chk("dup_conf", 32'(conflict), 1);
    chk("dup_row", 32'(rowBad), 32'h2);
    chk("dup_col", 32'(colBad), 32'h8);
    chk("dup_box", 32'(boxBad), 32'h2);

    // solved board with cell (2,3) blank
    load_solved();
    mem[2] = mk(2, 1, 4, 3, 4'b1000);
    scan("blank");
    chk("blank_gc", 32'(gameComplete), 0);
    chk("blank_conf", 32'(conflict), 0);
    chk("blank_masks", {rowBad, colBad, boxBad}, 0);

    // row 0 digit 0 = 5, out of range
    load_solved();
    mem[0] = mk(5, 2, 3, 4, 4'b0000);
    scan("range");
    chk("range_gc", 32'(gameComplete), 0);
    chk("range_conf", 32'(conflict), 0);
    chk("range_row", 32'(rowBad), 32'h1);
    chk("range_col", 32'(colBad), 32'h1);
    chk("range_box", 32'(boxBad), 32'h1);

    // start re-issued at E0+2 and again coincident with EVAL: both ignored
    load_solved();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n_done = 0;
    done_at = 0;
    for (int i = 3; i <= 12; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (i == 3) chk("busy_restart_addr", 32'(RamAddr), 3);
      if (done) begin
        n_done++;
        if (n_done == 1) done_at = i;
        start = 1'b1;
      end
    end
    start = 1'b0;
    chk("busy_done_count", n_done, 1);
    chk("busy_done_cycle", done_at, 5);
    chk("busy_gc", 32'(gameComplete), 1);
    chk("eval_start_ignored", {busy, RamRe}, 0);

    // all-blank board after a good result
    for (int r = 0; r < N; r++) mem[r] = mk(0, 0, 0, 0, 4'b1111);
    scan("allblank");
    chk("allblank_gc", 32'(gameComplete), 0);
    chk("allblank_conf", 32'(conflict), 0);
    chk("allblank_masks", {rowBad, colBad, boxBad}, 0);

    // reset mid-scan
    load_solved();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_addr", 32'(RamAddr), 0);
    chk("midrst_ctrl", {RamRe, busy, done}, 0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK); RST = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge CLK);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    scan("after_rst");
    chk("after_rst_gc", 32'(gameComplete), 1);
    chk("after_rst_masks", {conflict, rowBad, colBad, boxBad}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
